exe_stage: RTL and testbench

Execute stage of the 5-stage ARM pipeline. Consumes the registered decode bundle from the ID/EXE pipeline register, generates the second operand (Val2), runs the ALU, computes the branch target, and owns the architectural NZCV status register. Results feed the EXE/MEM pipeline register. Branch outputs go to fetch, status goes to decode for condition checks, and `busy` goes to the hazard unit.

---
 rtl/exe_stage.sv | 161 ++++++++++++++++
 tb/tb_exe_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - ARM execute stage: Val2 generation, ALU, branch target and NZCV status register
// Define EXE_MUL_EN to add a 33-cycle shift-add multiplier for EXE_CMD 1010.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN_IN,
  input  logic        MEM_R_EN_IN,
  input  logic        MEM_W_EN_IN,
  input  logic        B_IN,
  input  logic        S_IN,
  input  logic        imm_IN,
  input  logic [3:0]  EXE_CMD_IN,
  input  logic [31:0] PC_IN,
  input  logic [31:0] Val_Rn_IN,
  input  logic [31:0] Val_Rm_IN,
  input  logic [11:0] Shift_operand_IN,
  input  logic [23:0] Signed_imm_24_IN,
  input  logic [3:0]  Dest_IN,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic [31:0] ALU_res,
  output logic [31:0] Val_Rm,
  output logic [3:0]  Dest,
  output logic        Br_taken,
  output logic [31:0] Br_addr,
  output logic [3:0]  SR,
  output logic        busy
);
  localparam logic [3:0] CMD_MOV = 4'b0001, CMD_ADD = 4'b0010, CMD_ADC = 4'b0011,
                         CMD_SUB = 4'b0100, CMD_SBC = 4'b0101, CMD_AND = 4'b0110,
                         CMD_ORR = 4'b0111, CMD_EOR = 4'b1000, CMD_MVN = 4'b1001,
                         CMD_MUL = 4'b1010;

  logic [31:0] val2;
  logic [4:0]  sh_amt;
  logic [63:0] rm_dbl, imm_dbl;
  logic [31:0] imm_word;

  assign sh_amt   = Shift_operand_IN[11:7];
  assign imm_word = {24'b0, Shift_operand_IN[7:0]};

  // Rotates are taken from the low half of a doubled word shifted right.
  always_comb begin
    rm_dbl  = {Val_Rm_IN, Val_Rm_IN} >> sh_amt;
    imm_dbl = {imm_word, imm_word} >> {Shift_operand_IN[11:8], 1'b0};
    val2    = '0;
    if (MEM_R_EN_IN | MEM_W_EN_IN)
      val2 = {20'b0, Shift_operand_IN};
    else if (imm_IN)
      val2 = imm_dbl[31:0];
    else begin
      case (Shift_operand_IN[6:5])
        2'b00:   val2 = Val_Rm_IN << sh_amt;
        2'b01:   val2 = Val_Rm_IN >> sh_amt;
        2'b10:   val2 = $signed(Val_Rm_IN) >>> sh_amt;
        default: val2 = rm_dbl[31:0];
      endcase
    end
  end

  logic        mul_busy, mul_done;
  logic [31:0] mul_res;

`ifdef EXE_MUL_EN
  localparam logic [1:0] ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2;
  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] mul_a, mul_b, mul_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
    end else begin
      case (state)
        ST_IDLE: if (EXE_CMD_IN == CMD_MUL) begin
          state   <= ST_BUSY;
          cnt     <= '0;
          mul_a   <= Val_Rn_IN;
          mul_b   <= val2;
          mul_acc <= '0;
        end
        ST_BUSY: begin
          if (mul_b[0]) mul_acc <= mul_acc + mul_a;
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mul_busy = (state == ST_BUSY) || (state == ST_IDLE && EXE_CMD_IN == CMD_MUL);
  assign mul_done = (state == ST_DONE);
  assign mul_res  = mul_done ? mul_acc : 32'd0;
`else
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = 32'd0;
`endif

  assign busy = ~rst & mul_busy;

  logic [31:0] add_b, res;
  logic        add_cin, is_arith;
  logic [32:0] sum;
  logic        v_flag;

  // Subtraction is Rn + ~Val2 + cin, so the carry out is the no-borrow flag.
  always_comb begin
    add_b    = val2;
    add_cin  = 1'b0;
    is_arith = 1'b1;
    case (EXE_CMD_IN)
      CMD_ADD: add_cin = 1'b0;
      CMD_ADC: add_cin = SR[1];
      CMD_SUB: begin add_b = ~val2; add_cin = 1'b1;  end
      CMD_SBC: begin add_b = ~val2; add_cin = SR[1]; end
      default: is_arith = 1'b0;
    endcase
    sum    = {1'b0, Val_Rn_IN} + {1'b0, add_b} + {32'b0, add_cin};
    v_flag = (Val_Rn_IN[31] == add_b[31]) && (sum[31] != Val_Rn_IN[31]);
    case (EXE_CMD_IN)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: res = sum[31:0];
      CMD_AND: res = Val_Rn_IN & val2;
      CMD_ORR: res = Val_Rn_IN | val2;
      CMD_EOR: res = Val_Rn_IN ^ val2;
      CMD_MUL: res = mul_res;
      default: res = 32'd0;
    endcase
  end

  logic sr_load;
  assign sr_load = S_IN && !busy && (EXE_CMD_IN != CMD_MUL || mul_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      SR <= 4'b0000;
    else if (sr_load)
      SR <= {res[31], res == 32'd0,
             is_arith ? sum[32] : SR[1],
             is_arith ? v_flag  : SR[0]};
  end

  assign ALU_res  = res;
  assign WB_EN    = WB_EN_IN    & ~busy;
  assign MEM_R_EN = MEM_R_EN_IN & ~busy;
  assign MEM_W_EN = MEM_W_EN_IN & ~busy;
  assign Br_taken = B_IN        & ~busy;
  assign Br_addr  = PC_IN + {{6{Signed_imm_24_IN[23]}}, Signed_imm_24_IN, 2'b00};
  assign Val_Rm   = Val_Rm_IN;
  assign Dest     = Dest_IN;
endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed self-checking bench for exe_stage
// Multiply checks are built when EXE_MUL_EN is defined; otherwise the disabled-path checks run.
module tb_exe_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, imm_IN;
  logic [3:0]  EXE_CMD_IN;
  logic [31:0] PC_IN, Val_Rn_IN, Val_Rm_IN;
  logic [11:0] Shift_operand_IN;
  logic [23:0] Signed_imm_24_IN;
  logic [3:0]  Dest_IN;
  logic        WB_EN, MEM_R_EN, MEM_W_EN, Br_taken, busy;
  logic [31:0] ALU_res, Val_Rm, Br_addr;
  logic [3:0]  Dest, SR;

  int n_cmp = 0;
  int n_fail = 0;

  exe_stage dut (
    .clk(clk), .rst(rst),
    .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
    .B_IN(B_IN), .S_IN(S_IN), .imm_IN(imm_IN), .EXE_CMD_IN(EXE_CMD_IN),
    .PC_IN(PC_IN), .Val_Rn_IN(Val_Rn_IN), .Val_Rm_IN(Val_Rm_IN),
    .Shift_operand_IN(Shift_operand_IN), .Signed_imm_24_IN(Signed_imm_24_IN),
    .Dest_IN(Dest_IN),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .ALU_res(ALU_res),
    .Val_Rm(Val_Rm), .Dest(Dest), .Br_taken(Br_taken), .Br_addr(Br_addr),
    .SR(SR), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    WB_EN_IN = 0; MEM_R_EN_IN = 0; MEM_W_EN_IN = 0; B_IN = 0; S_IN = 0; imm_IN = 0;
    EXE_CMD_IN = 4'b0000; PC_IN = 0; Val_Rn_IN = 0; Val_Rm_IN = 0;
    Shift_operand_IN = 0; Signed_imm_24_IN = 0; Dest_IN = 0;
  endtask

  task automatic alu_op(input logic [3:0] cmd, input logic s, input logic im,
                        input logic [31:0] rn, input logic [31:0] rm, input logic [11:0] sh);
    clear_inputs();
    EXE_CMD_IN = cmd; S_IN = s; imm_IN = im; Val_Rn_IN = rn; Val_Rm_IN = rm;
    Shift_operand_IN = sh;
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    check("reset_sr", {28'b0, SR}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;

    // ADD 0x7FFFFFFF + #1 overflows into N and V
    alu_op(4'b0010, 1, 1, 32'h7FFF_FFFF, 32'h0, 12'h001);
    check("add_res", ALU_res, 32'h8000_0000);
    tick();
    check("add_sr", {28'b0, SR}, 32'h9);

    // asynchronous reset mid-cycle
    #3 rst = 1'b1;
    #1;
    check("async_rst_sr", {28'b0, SR}, 32'h0);
    check("async_rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    S_IN = 0;
    tick();

    alu_op(4'b0100, 1, 0, 32'd5, 32'd5, 12'h000);
    check("sub_res", ALU_res, 32'h0);
    tick();
    check("sub_sr", {28'b0, SR}, 32'h6);

    alu_op(4'b0110, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 12'h000);
    check("and_res", ALU_res, 32'hFFFF_FFFF);
    tick();
    check("and_sr", {28'b0, SR}, 32'hA);

    // Val2 generation
    alu_op(4'b0001, 0, 1, 32'h0, 32'h0, 12'h4FF);
    check("imm_rotate", ALU_res, 32'hFF00_0000);
    alu_op(4'b0001, 0, 0, 32'h0, 32'h8000_0000, 12'h240);
    check("asr4", ALU_res, 32'hF800_0000);
    alu_op(4'b0001, 0, 0, 32'h0, 32'h8000_0000, 12'h220);
    check("lsr4", ALU_res, 32'h0800_0000);
    alu_op(4'b0001, 0, 0, 32'h0, 32'h0000_000F, 12'h260);
    check("ror4", ALU_res, 32'hF000_0000);
    alu_op(4'b1001, 0, 0, 32'h0, 32'h1, 12'h080);
    check("mvn_lsl1", ALU_res, 32'hFFFF_FFFD);
    alu_op(4'b0111, 0, 0, 32'hF0F0_0000, 32'h0000_0F0F, 12'h000);
    check("orr", ALU_res, 32'hF0F0_0F0F);
    alu_op(4'b1000, 0, 0, 32'hFFFF_0000, 32'hFF00_FF00, 12'h000);
    check("eor", ALU_res, 32'h00FF_FF00);

    // memory offset wins over the immediate rotate
    alu_op(4'b0010, 0, 1, 32'h0000_1000, 32'h0, 12'h804);
    MEM_R_EN_IN = 1; WB_EN_IN = 1; Dest_IN = 4'hC; Val_Rm_IN = 32'hDEAD_BEEF;
    #1;
    check("mem_addr", ALU_res, 32'h0000_1804);
    check("mem_r_en", {31'b0, MEM_R_EN}, 32'h1);
    check("wb_en_pass", {31'b0, WB_EN}, 32'h1);
    check("dest_pass", {28'b0, Dest}, 32'hC);
    check("val_rm_pass", Val_Rm, 32'hDEAD_BEEF);

    // branch
    clear_inputs();
    B_IN = 1; PC_IN = 32'h100; Signed_imm_24_IN = 24'hFFFFFE;
    #1;
    check("br_taken", {31'b0, Br_taken}, 32'h1);
    check("br_addr_back", Br_addr, 32'h0000_00F8);
    Signed_imm_24_IN = 24'h000010;
    #1;
    check("br_addr_fwd", Br_addr, 32'h0000_0140);

    // carry-in ops; C = 1 from AND
    alu_op(4'b0011, 0, 1, 32'd1, 32'h0, 12'h002);
    check("adc_c1", ALU_res, 32'd4);
    alu_op(4'b0101, 0, 1, 32'd10, 32'h0, 12'h003);
    check("sbc_c1", ALU_res, 32'd7);
    alu_op(4'b0100, 1, 1, 32'd3, 32'h0, 12'h005);
    check("sub_borrow", ALU_res, 32'hFFFF_FFFE);
    tick();
    check("sub_borrow_sr", {28'b0, SR}, 32'h8);
    alu_op(4'b0101, 0, 1, 32'd10, 32'h0, 12'h003);
    check("sbc_c0", ALU_res, 32'd6);
    alu_op(4'b0011, 0, 1, 32'd1, 32'h0, 12'h002);
    check("adc_c0", ALU_res, 32'd3);
    alu_op(4'b1111, 0, 1, 32'd1, 32'h0, 12'h002);
    check("undef_cmd", ALU_res, 32'd0);

    // set SR = 0110 so C preservation through the multiply is visible
    alu_op(4'b0100, 1, 0, 32'd5, 32'd5, 12'h000);
    tick();
    check("pre_mul_sr", {28'b0, SR}, 32'h6);

`ifdef EXE_MUL_EN
    alu_op(4'b1010, 1, 0, 32'd7, 32'd6, 12'h000);
    WB_EN_IN = 1;
    for (int i = 1; i <= 33; i++) begin
      #1;
      check($sformatf("mul_busy_c%0d", i), {31'b0, busy}, 32'h1);
      check($sformatf("mul_wb_c%0d", i), {31'b0, WB_EN}, 32'h0);
      check($sformatf("mul_sr_c%0d", i), {28'b0, SR}, 32'h6);
      tick();
    end
    #1;
    check("mul_done_busy", {31'b0, busy}, 32'h0);
    check("mul_res", ALU_res, 32'd42);
    check("mul_wb", {31'b0, WB_EN}, 32'h1);
    tick();
    clear_inputs();
    check("mul_sr", {28'b0, SR}, 32'h2);

    // abort a multiply with reset in cycle 10
    tick();
    alu_op(4'b1010, 1, 0, 32'd7, 32'd6, 12'h000);
    for (int i = 1; i < 10; i++) tick();
    #2 rst = 1'b1;
    #1;
    check("mul_rst_busy", {31'b0, busy}, 32'h0);
    check("mul_rst_sr", {28'b0, SR}, 32'h0);
    clear_inputs();
    tick();
    rst = 1'b0;
    tick();
    check("mul_post_rst_busy", {31'b0, busy}, 32'h0);
    check("mul_post_rst_sr", {28'b0, SR}, 32'h0);
`else
    alu_op(4'b1010, 1, 0, 32'd7, 32'd6, 12'h000);
    WB_EN_IN = 1;
    #1;
    check("nomul_res", ALU_res, 32'd0);
    check("nomul_busy", {31'b0, busy}, 32'h0);
    check("nomul_wb", {31'b0, WB_EN}, 32'h1);
    tick();
    check("nomul_sr", {28'b0, SR}, 32'h6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
